// File: rtl/rptr_handler.sv
// Read-side pointer controller for the async FIFO: synchronises the Gray write pointer,
// tracks read pointers and flags, and drives a first-word-fall-through output register.
module rptr_handler #(
  parameter int PTR_WIDTH     = 3,
  parameter int DATA_WIDTH    = 8,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  rclk,
  input  logic                  r_rst,
  input  logic [PTR_WIDTH:0]    g_wptr_async,
  input  logic [DATA_WIDTH-1:0] rdata_mem,
  output logic [PTR_WIDTH-1:0]  raddr,
  output logic [PTR_WIDTH:0]    b_rptr,
  output logic [PTR_WIDTH:0]    g_rptr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    rlevel,
  output logic                  level_err
);

  localparam logic [PTR_WIDTH:0] AE_THRESH = (PTR_WIDTH+1)'(AEMPTY_THRESH);
  localparam logic [PTR_WIDTH:0] DEPTH     = {1'b1, {PTR_WIDTH{1'b0}}};

  logic [PTR_WIDTH:0] s1_reg;
  logic [PTR_WIDTH:0] g_wptr_sync_reg;
  logic [PTR_WIDTH:0] b_wptr_sync;
  logic [PTR_WIDTH:0] b_rptr_next;
  logic [PTR_WIDTH:0] g_rptr_next;
  logic [PTR_WIDTH:0] level_next;
  logic               mem_pop;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
  genvar gi;
  generate
    for (gi = 0; gi <= PTR_WIDTH; gi++) begin : g_gray2bin
      assign b_wptr_sync[gi] = ^g_wptr_sync_reg[PTR_WIDTH:gi];
    end
  endgenerate

  assign mem_pop     = !empty && (!dout_valid || dout_ready);
  assign b_rptr_next = b_rptr + {{PTR_WIDTH{1'b0}}, mem_pop};
  assign g_rptr_next = (b_rptr_next >> 1) ^ b_rptr_next;
  assign level_next  = b_wptr_sync - b_rptr_next;
  assign raddr       = b_rptr[PTR_WIDTH-1:0];

  always_ff @(posedge rclk) begin
    if (r_rst) begin
      s1_reg          <= '0;
      g_wptr_sync_reg <= '0;
    end else begin
      s1_reg          <= g_wptr_async;
      g_wptr_sync_reg <= s1_reg;
    end
  end

  // Flags are computed against the synchronised write pointer, so they can only lag reality
  always_ff @(posedge rclk) begin
    if (r_rst) begin
      b_rptr       <= '0;
      g_rptr       <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rlevel       <= '0;
      level_err    <= 1'b0;
    end else begin
      b_rptr       <= b_rptr_next;
      g_rptr       <= g_rptr_next;
      empty        <= (g_rptr_next == g_wptr_sync_reg);
      almost_empty <= (level_next <= AE_THRESH);
      rlevel       <= level_next;
      level_err    <= level_err | (level_next > DEPTH);
    end
  end

  // A pop reloads dout in the same edge a consumed word leaves, keeping one word per cycle
  always_ff @(posedge rclk) begin
    if (r_rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (mem_pop) begin
      dout       <= rdata_mem;
      dout_valid <= 1'b1;
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rptr_handler.sv
// Scoreboard bench for rptr_handler: a write-side model fills a small memory and
// queues expected words; each output transfer pops and compares one.
module tb_rptr_handler;

  logic       rclk = 1'b0;
  logic       r_rst;
  logic [3:0] g_wptr_async;
  logic [7:0] rdata_mem;
  logic [2:0] raddr;
  logic [3:0] b_rptr;
  logic [3:0] g_rptr;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       empty;
  logic       almost_empty;
  logic [3:0] rlevel;
  logic       level_err;

  logic [7:0] mem [8];
  logic [7:0] exp_q [$];
  logic [3:0] wptr;
  int         errors = 0;
  int         checks = 0;
  int         xfers  = 0;

  rptr_handler #(.PTR_WIDTH(3), .DATA_WIDTH(8), .AEMPTY_THRESH(1)) dut (
    .rclk         (rclk),
    .r_rst        (r_rst),
    .g_wptr_async (g_wptr_async),
    .rdata_mem    (rdata_mem),
    .raddr        (raddr),
    .b_rptr       (b_rptr),
    .g_rptr       (g_rptr),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rlevel       (rlevel),
    .level_err    (level_err)
  );

  always #5 rclk = ~rclk;
  assign rdata_mem = mem[raddr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  // Writer model: store the word, queue it, then publish the advanced Gray pointer
  task automatic write_word(input logic [7:0] d);
    mem[wptr[2:0]] = d;
    exp_q.push_back(d);
    wptr = wptr + 4'd1;
    g_wptr_async = to_gray(wptr);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_b_rptr"}, 32'(b_rptr), 0);
    check({tag, "_g_rptr"}, 32'(g_rptr), 0);
    check({tag, "_raddr"}, 32'(raddr), 0);
    check({tag, "_dout"}, 32'(dout), 0);
    check({tag, "_dout_valid"}, 32'(dout_valid), 0);
    check({tag, "_empty"}, 32'(empty), 1);
    check({tag, "_almost_empty"}, 32'(almost_empty), 1);
    check({tag, "_rlevel"}, 32'(rlevel), 0);
    check({tag, "_level_err"}, 32'(level_err), 0);
  endtask

  // Transfer monitor: inputs change only #1 after an edge, so pre-edge values are seen here
  always @(posedge rclk) begin
    logic [31:0] exp_val;
    if (!r_rst && dout_valid && dout_ready) begin
      xfers++;
      exp_val = (exp_q.size() != 0) ? {24'b0, exp_q.pop_front()} : 32'h100;
      $display("xfer %0d: dout=%02h expected=%0h", xfers, dout, exp_val);
      check("xfer_data", 32'(dout), exp_val);
    end
  end

  initial begin
    int   start;
    int   gaps;
    int   spurious_empty;
    int   written;
    logic seen_b_wrap;
    logic seen_g_wrap;
    logic [3:0] prev_b;
    logic [3:0] prev_g;
    logic [3:0] lvl_exp [4];
    logic       ae_exp  [4];

    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    wptr = 4'd0;
    r_rst = 1'b1;
    dout_ready = 1'b0;
    g_wptr_async = 4'b0101;

    // Reset with a nonzero write pointer at the input
    tick();
    tick();
    check_reset_state("reset");
    g_wptr_async = 4'b0000;
    tick();
    r_rst = 1'b0;

    // Single-word latency: E0..E3 after the pointer change
    write_word(8'hA5);
    tick();
    tick();
    check("lat_e1_empty", 32'(empty), 1);
    tick();
    check("lat_e2_empty", 32'(empty), 0);
    check("lat_e2_rlevel", 32'(rlevel), 1);
    check("lat_e2_valid", 32'(dout_valid), 0);
    tick();
    check("lat_e3_dout", 32'(dout), 32'hA5);
    check("lat_e3_valid", 32'(dout_valid), 1);
    check("lat_e3_b_rptr", 32'(b_rptr), 1);
    check("lat_e3_g_rptr", 32'(g_rptr), 32'b0001);
    check("lat_e3_empty", 32'(empty), 1);
    check("lat_e3_rlevel", 32'(rlevel), 0);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    check("lat_consumed_valid", 32'(dout_valid), 0);

    // Back-pressure: eight words, consumer stalled
    for (int i = 0; i < 8; i++) write_word(8'h10 + 8'(i));
    repeat (6) tick();
    check("bp_b_rptr", 32'(b_rptr), 2);
    check("bp_rlevel", 32'(rlevel), 7);
    check("bp_dout", 32'(dout), 32'h10);
    check("bp_valid", 32'(dout_valid), 1);
    repeat (3) tick();
    check("bp_dout_stable", 32'(dout), 32'h10);
    check("bp_b_rptr_stable", 32'(b_rptr), 2);
    start = xfers;
    dout_ready = 1'b1;
    for (int c = 0; c < 30 && !(empty && !dout_valid); c++) tick();
    check("bp_xfers", 32'(xfers - start), 8);
    check("bp_empty", 32'(empty), 1);
    check("bp_valid_end", 32'(dout_valid), 0);

    // Wrap-around streaming, one word per cycle
    start = xfers;
    gaps = 0;
    spurious_empty = 0;
    written = 0;
    seen_b_wrap = 1'b0;
    seen_g_wrap = 1'b0;
    prev_b = b_rptr;
    prev_g = g_rptr;
    for (int c = 0; c < 200 && (xfers - start) < 20; c++) begin
      if (written < 20 && 4'(wptr - b_rptr) < 4'd8) begin
        write_word(8'h40 + 8'(written));
        written++;
      end
      tick();
      if (prev_b == 4'd15 && b_rptr == 4'd0) seen_b_wrap = 1'b1;
      if (prev_g == 4'b1000 && g_rptr == 4'b0000) seen_g_wrap = 1'b1;
      prev_b = b_rptr;
      prev_g = g_rptr;
      if ((xfers - start) > 0 && (xfers - start) < 20 && !dout_valid) gaps++;
      if ((xfers - start) > 0 && written < 20 && empty) spurious_empty++;
    end
    check("wrap_xfers", 32'(xfers - start), 20);
    check("wrap_b_seen", 32'(seen_b_wrap), 1);
    check("wrap_g_seen", 32'(seen_g_wrap), 1);
    check("wrap_gaps", 32'(gaps), 0);
    check("wrap_spurious_empty", 32'(spurious_empty), 0);

    // Almost-empty threshold: level 3, 2, 1, 0
    dout_ready = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) write_word(8'h80 + 8'(i));
    repeat (6) tick();
    lvl_exp = '{4'd3, 4'd2, 4'd1, 4'd0};
    ae_exp  = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int s = 0; s < 4; s++) begin
      if (s > 0) begin
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        tick();
      end
      check($sformatf("ae_level_%0d", s), 32'(rlevel), 32'(lvl_exp[s]));
      check($sformatf("ae_flag_%0d", s), 32'(almost_empty), 32'(ae_exp[s]));
    end
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    tick();
    check("ae_drained_valid", 32'(dout_valid), 0);
    check("ae_queue_left", 32'(exp_q.size()), 0);

    // Illegal level from a bogus write pointer, then reset mid-stream
    r_rst = 1'b1;
    g_wptr_async = 4'b0000;
    tick();
    r_rst = 1'b0;
    exp_q.delete();
    wptr = 4'd0;
    for (int i = 0; i < 8; i++) mem[i] = 8'hC0 + 8'(i);
    tick();
    check("err_start_b_rptr", 32'(b_rptr), 0);
    check("err_start_flag", 32'(level_err), 0);
    g_wptr_async = 4'b1010;
    repeat (5) tick();
    check("err_set", 32'(level_err), 1);
    g_wptr_async = 4'b0000;
    repeat (5) tick();
    check("err_sticky", 32'(level_err), 1);
    check("err_dout_held", 32'(dout_valid), 1);
    r_rst = 1'b1;
    tick();
    check_reset_state("midrst");
    r_rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
